// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite layer.
// The update bundle carries one complete position/frame/flip request.
package sprite_pkg;

  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int FRAME_MAX_W = 8;

  typedef struct packed {
    logic [9:0]             x;
    logic [9:0]             y;
    logic [FRAME_MAX_W-1:0] frame;
    logic                   anim;
    logic                   flip;
  } upd_t;

  function automatic int addr_w(input int nf, input int w, input int h);
    return $clog2(nf * w * h);
  endfunction

endpackage

// File: rtl/sprite_anim_ctrl.sv
// Update handshake, pending/active registers and animation frame stepping.
// Exposes next-state active values so the frame-start pixel already sees them.
module sprite_anim_ctrl
  import sprite_pkg::*;
#(
  parameter int NUM_FRAMES = 8,
  parameter int ANIM_DIV   = 6,
  parameter int FW         = $clog2(NUM_FRAMES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_start,
  input  logic          upd_valid,
  input  upd_t          upd,
  output logic          upd_ready,
  output logic [9:0]    act_x,
  output logic [9:0]    act_y,
  output logic [FW-1:0] act_frame,
  output logic          act_flip
);

  localparam int CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [FRAME_MAX_W-1:0] FMASK = FRAME_MAX_W'(NUM_FRAMES - 1);

  upd_t          pend_q, pend_d;
  upd_t          act_q, act_d;
  logic          pending_q, pending_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    pend_d    = pend_q;
    pending_d = pending_q;
    act_d     = act_q;
    cnt_d     = cnt_q;
    if (frame_start && pending_q) begin
      act_d     = pend_q;
      pending_d = 1'b0;
      cnt_d     = '0;
    end else if (frame_start && act_q.anim) begin
      if (cnt_q == CW'(ANIM_DIV - 1)) begin
        cnt_d       = '0;
        act_d.frame = (act_q.frame + FRAME_MAX_W'(1)) & FMASK;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // Commit tests the registered pending flag, so a request taken on the
    // frame-start cycle waits a full frame.
    if (upd_valid && !pending_q) begin
      pend_d    = upd;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q    <= '0;
      pending_q <= 1'b0;
      act_q     <= '0;
      cnt_q     <= '0;
    end else begin
      pend_q    <= pend_d;
      pending_q <= pending_d;
      act_q     <= act_d;
      cnt_q     <= cnt_d;
    end
  end

  assign upd_ready = ~pending_q;
  assign act_x     = act_d.x;
  assign act_y     = act_d.y;
  assign act_frame = act_d.frame[FW-1:0];
  assign act_flip  = act_d.flip;

endmodule

// File: rtl/sprite_layer.sv
// Animated, scaled, mirrored sprite with colour-key transparency.
// Three-stage pipeline: address, ROM access, output register.
module sprite_layer
  import sprite_pkg::*;
#(
  parameter int SPR_W      = 64,
  parameter int SPR_H      = 64,
  parameter int NUM_FRAMES = 8,
  parameter int IDX_W      = 4,
  parameter int SCALE_LOG2 = 0,
  parameter int TRANSP_IDX = 0,
  parameter int ANIM_DIV   = 6,
  parameter int ADDR_W     = addr_w(NUM_FRAMES, SPR_W, SPR_H)
) (
  input  logic                          vga_clk,
  input  logic                          reset,
  input  logic [9:0]                    DrawX,
  input  logic [9:0]                    DrawY,
  input  logic                          blank,
  input  logic                          upd_valid,
  output logic                          upd_ready,
  input  logic [9:0]                    upd_x,
  input  logic [9:0]                    upd_y,
  input  logic [$clog2(NUM_FRAMES)-1:0] upd_frame,
  input  logic                          upd_anim,
  input  logic                          upd_flip,
  output logic [ADDR_W-1:0]             rom_address,
  input  logic [IDX_W-1:0]              rom_q,
  output logic [IDX_W-1:0]              pix_idx,
  output logic                          pix_hit,
  output logic                          blank_d
);

  localparam int FW  = $clog2(NUM_FRAMES);
  localparam int TXW = $clog2(SPR_W);
  localparam int TYW = $clog2(SPR_H);
  localparam logic [10:0] BOX_W = 11'(SPR_W << SCALE_LOG2);
  localparam logic [10:0] BOX_H = 11'(SPR_H << SCALE_LOG2);

  upd_t          upd;
  logic          frame_start;
  logic [9:0]    act_x, act_y;
  logic [FW-1:0] act_frame;
  logic          act_flip;

  always_comb begin
    upd       = '0;
    upd.x     = upd_x;
    upd.y     = upd_y;
    upd.frame = FRAME_MAX_W'(upd_frame);
    upd.anim  = upd_anim;
    upd.flip  = upd_flip;
  end

  assign frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);

  sprite_anim_ctrl #(
    .NUM_FRAMES(NUM_FRAMES),
    .ANIM_DIV  (ANIM_DIV)
  ) u_ctrl (
    .clk        (vga_clk),
    .reset      (reset),
    .frame_start(frame_start),
    .upd_valid  (upd_valid),
    .upd        (upd),
    .upd_ready  (upd_ready),
    .act_x      (act_x),
    .act_y      (act_y),
    .act_frame  (act_frame),
    .act_flip   (act_flip)
  );

  // Bit 10 of the difference is the sign: left of / above the sprite.
  logic [10:0]       dx, dy;
  logic              in_box_c;
  logic [TXW-1:0]    tx_raw, tx;
  logic [TYW-1:0]    ty;
  logic [ADDR_W-1:0] addr_c;

  assign dx       = {1'b0, DrawX} - {1'b0, act_x};
  assign dy       = {1'b0, DrawY} - {1'b0, act_y};
  assign in_box_c = blank && !dx[10] && (dx < BOX_W)
                          && !dy[10] && (dy < BOX_H);
  assign tx_raw   = dx[SCALE_LOG2 +: TXW];
  assign ty       = dy[SCALE_LOG2 +: TYW];
  assign tx       = act_flip ? ~tx_raw : tx_raw;
  assign addr_c   = ADDR_W'({act_frame, ty, tx});

  logic [ADDR_W-1:0] addr_q;
  logic              in_box_q1, in_box_q2;
  logic              blank_q1, blank_q2, blank_q3;
  logic [IDX_W-1:0]  idx_q;
  logic              hit_q;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      addr_q    <= '0;
      in_box_q1 <= 1'b0;
      in_box_q2 <= 1'b0;
      blank_q1  <= 1'b0;
      blank_q2  <= 1'b0;
      blank_q3  <= 1'b0;
      idx_q     <= '0;
      hit_q     <= 1'b0;
    end else begin
      if (in_box_c) addr_q <= addr_c;
      in_box_q1 <= in_box_c;
      blank_q1  <= blank;
      in_box_q2 <= in_box_q1;
      blank_q2  <= blank_q1;
      idx_q     <= rom_q;
      hit_q     <= in_box_q2 && (rom_q != IDX_W'(TRANSP_IDX));
      blank_q3  <= blank_q2;
    end
  end

  assign rom_address = addr_q;
  assign pix_idx     = idx_q;
  assign pix_hit     = hit_q;
  assign blank_d     = blank_q3;

endmodule

// File: doc/sprite_layer.md
Name: sprite_layer

Overview:
- Parametrised successor to the single full-screen ROM sprite: draws one animated sprite from a multi-frame palette-index ROM at a programmable screen position, with integer power-of-two scaling, horizontal mirroring and colour-key transparency.
- Sits between the VGA timing generator and the palette/compositor. It drives an external synchronous ROM and emits a palette index plus a hit flag, pipeline-aligned with a delayed blank.
- Position, frame and flip changes arrive by valid/ready handshake. They take effect only at frame start, so a frame never tears.

Parameters:
- SPR_W, 64, sprite width in texels (power of two)
- SPR_H, 64, sprite height in texels (power of two)
- NUM_FRAMES, 8, animation frames stored back-to-back in the ROM (power of two)
- IDX_W, 4, palette index width
- SCALE_LOG2, 0, each texel covers 2^SCALE_LOG2 × 2^SCALE_LOG2 screen pixels
- TRANSP_IDX, 0, palette index treated as transparent
- ANIM_DIV, 6, video frames per animation step (≥1)
- ADDR_W, $clog2(NUM_FRAMES*SPR_W*SPR_H), ROM address width (15 with defaults)

Ports:
- vga_clk  in  1  pixel clock; the only clock
- reset  in  1  synchronous, active-high reset
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- blank  in  1  1 = active video
- upd_valid  in  1  update request
- upd_ready  out  1  block can accept an update
- upd_x  in  10  new sprite left edge
- upd_y  in  10  new sprite top edge
- upd_frame  in  $clog2(NUM_FRAMES)  static frame, used when upd_anim=0
- upd_anim  in  1  1 = auto-animate
- upd_flip  in  1  1 = mirror horizontally
- rom_address  out  ADDR_W  registered ROM address
- rom_q  in  IDX_W  ROM data, valid one cycle after rom_address is sampled
- pix_idx  out  IDX_W  palette index of the sprite pixel
- pix_hit  out  1  sprite is opaque at this pixel
- blank_d  out  1  blank delayed to align with pix_*

Behaviour:
- Reset values: all outputs 0 except upd_ready=1. Active registers: pos=(0,0), frame=0, anim=0, flip=0. pending=0, anim_cnt=0.
- Handshake: an update is accepted when upd_valid && upd_ready and is stored in the pending registers. upd_ready = ~pending.
- Frame start is the cycle with DrawX==0 && DrawY==0.
- At frame start, if pending=1: copy pending values to active, set pending=0, clear anim_cnt. An update accepted on the frame-start cycle itself waits for the next frame start.
- Animation: when anim=1, anim_cnt increments at each frame start that does not commit an update.
  - When anim_cnt reaches ANIM_DIV-1 it resets to 0 and the frame index advances.
  - The frame index wraps from NUM_FRAMES-1 to 0.
  - When anim=0, the frame index is fixed at the committed upd_frame.
- Stage 1, registered at the edge after DrawX/DrawY are presented:
  - dx = DrawX − pos_x and dy = DrawY − pos_y, computed 11-bit signed.
  - in_box = dx ≥ 0, dx < SPR_W<<SCALE_LOG2, dy ≥ 0, dy < SPR_H<<SCALE_LOG2, and blank=1.
  - tx = dx>>SCALE_LOG2, or SPR_W−1−that value when flip=1. ty = dy>>SCALE_LOG2.
  - rom_address = frame*SPR_W*SPR_H + ty*SPR_W + tx. Products are concatenations only; no multipliers.
  - When in_box=0, rom_address holds its previous value.
- The sprite clips at the right and bottom screen edges naturally. pos_x beyond 639 yields no hit.
- Stage 2: in_box and blank advance alongside the ROM access.
- Stage 3, the output register: pix_idx = rom_q; pix_hit = in_box_d2 && rom_q != TRANSP_IDX; blank_d = blank_d3.
- Latency: exactly 3 vga_clk cycles from DrawX/DrawY/blank to pix_*/blank_d.
- When pix_hit=0, pix_idx is don't-care; the bench checks only pix_hit.
- Reset mid-frame: the pipeline flushes to zeros and pending is dropped. The sprite reappears at (0,0), frame 0, from the next pixel.

Decomposition:
- Package sprite_pkg: the ADDR_W function, the update struct {x, y, frame, anim, flip} and the SCREEN_W/SCREEN_H constants (640/480).
- One sub-module, sprite_anim_ctrl, owns the handshake, pending/active registers, anim_cnt and frame index. The top level holds the address pipeline.

Test Plan:
- Reset, then sweep one frame with default registers and a ROM model where texel = address[3:0] → pix_hit=0 wherever the index is 0; pix_idx at (5,0) = 5, three cycles after DrawX=5.
- Update x=100, y=50, frame=3, anim=0 mid-frame → upd_ready drops. The current frame is unchanged. From the next frame, the first hit is at (100,50) with rom_address=3*4096=12288.
- SCALE_LOG2=1, pos=(0,0) → DrawX=0 and DrawX=1 both produce address 0. DrawX=128 falls outside the box, so pix_hit=0.
- upd_flip=1, pos=(0,0) → DrawX=0 gives tx=63, i.e. address 63 in frame 0.
- anim=1, ANIM_DIV=2 → the frame index sequence over successive frame starts is 0,0,1,1,…,7,7,0 (wrap).
- Update accepted on the frame-start cycle, and a reset asserted mid-line → the update commits one frame later. After reset, outputs are 0, upd_ready=1 and pending is cleared.
